// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq
// Brief    : Valid/ready micro-instruction sequencer for the register-file/ALU
//            datapath: FIFO buffering, issue/exec sequencing, result capture.
// Revision : 1.0
// ============================================================================
module datapath_seq #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [8:0]  in_instr,
    output logic        in_ready,
    output logic [1:0]  addr1,
    output logic [1:0]  addr2,
    output logic [1:0]  addr3,
    output logic [2:0]  alu,
    output logic        wr,
    input  logic [31:0] result,
    input  logic        cout,
    output logic [31:0] res_q,
    output logic        cout_q,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t               r_state;
    logic [8:0]           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_addr1;
    logic [1:0]           r_addr2;
    logic [1:0]           r_addr3;
    logic [2:0]           r_alu;
    logic                 r_wr;
    logic [31:0]          r_res_q;
    logic                 r_cout_q;
    logic                 r_done;
    logic                 r_err;

    logic                 w_push;
    logic                 w_pop;
    logic [8:0]           w_head_instr;

    // Readiness comes only from the registered count, so a pop on the same
    // edge never frees a slot for a push on that edge.
    assign in_ready     = (r_count != c_FULL);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_instr = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr1  <= 2'd0;
            r_addr2  <= 2'd0;
            r_addr3  <= 2'd0;
            r_alu    <= 3'd0;
            r_wr     <= 1'b0;
            r_res_q  <= 32'd0;
            r_cout_q <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu   <= w_head_instr[8:6];
                        r_addr3 <= w_head_instr[5:4];
                        r_addr1 <= w_head_instr[3:2];
                        r_addr2 <= w_head_instr[1:0];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Ops with alu[2] set are illegal and must never write back.
                    r_wr    <= ~r_alu[2];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_wr   <= 1'b0;
                    r_done <= 1'b1;
                    if (r_alu[2]) begin
                        r_err <= 1'b1;
                    end else begin
                        r_res_q  <= result;
                        r_cout_q <= cout;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wr    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign addr1  = r_addr1;
    assign addr2  = r_addr2;
    assign addr3  = r_addr3;
    assign alu    = r_alu;
    assign wr     = r_wr;
    assign res_q  = r_res_q;
    assign cout_q = r_cout_q;
    assign done   = r_done;
    assign err    = r_err;
    assign busy   = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire
